// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller.
// 16 lines of 32-byte blocks, one outstanding block transfer at a time.
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cpu_req_i,
    input  logic         cpu_write_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        UPDATE
    } stateE;

    stateE state;
    stateE stateNext;

    logic [3:0]   index;
    logic [22:0]  tag;
    logic [2:0]   word;
    logic [7:0]   wordBit;

    logic         validQ [16];
    logic         dirtyQ [16];
    logic [22:0]  tagQ   [16];
    logic [255:0] dataQ  [16];

    logic         hit;
    logic         storeHit;
    logic         fill;
    logic [31:0]  hitWord;
    logic         unusedBits;

    assign index      = cpu_addr_i[8:5];
    assign tag        = cpu_addr_i[31:9];
    assign word       = cpu_addr_i[4:2];
    assign wordBit    = {word, 5'b0};
    assign unusedBits = ^cpu_addr_i[1:0];

    assign hit      = cpu_req_i & validQ[index] & (tagQ[index] == tag);
    assign storeHit = (state == IDLE) & hit & cpu_write_i;
    assign fill     = (state == ALLOCATE) & mem_ack_i;
    assign hitWord  = dataQ[index][wordBit +: 32];

    // State register; reset abandons any block transfer in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Line status bits: cleared by reset, set by store hits and fills
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                validQ[i] <= 1'b0;
                dirtyQ[i] <= 1'b0;
            end
        end else begin
            if (storeHit) begin
                dirtyQ[index] <= 1'b1;
            end
            if (fill) begin
                validQ[index] <= 1'b1;
                dirtyQ[index] <= 1'b0;
            end
        end
    end

    // Tag and data storage; contents are meaningless until valid is set
    always_ff @(posedge clk_i) begin
        if (storeHit) begin
            dataQ[index][wordBit +: 32] <= cpu_data_i;
        end
        if (fill) begin
            tagQ[index]  <= tag;
            dataQ[index] <= mem_data_i;
        end
    end

    // Next-state: a miss writes back a dirty victim before fetching
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    if (validQ[index] && dirtyQ[index]) begin
                        stateNext = WRITEBACK;
                    end else begin
                        stateNext = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack_i) begin
                    stateNext = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    stateNext = UPDATE;
                end
            end
            UPDATE: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Outputs: forced low while reset is held, bus driven only mid-transfer
    always_comb begin
        cpu_data_o   = '0;
        cpu_stall_o  = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        if (!rst_i) begin
            unique case (state)
                IDLE: begin
                    cpu_stall_o = cpu_req_i & ~hit;
                    if (hit && !cpu_write_i) begin
                        cpu_data_o = hitWord;
                    end
                end
                WRITEBACK: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_write_o  = 1'b1;
                    mem_addr_o   = {tagQ[index], index, 5'b0};
                    mem_data_o   = dataQ[index];
                end
                ALLOCATE: begin
                    cpu_stall_o  = 1'b1;
                    mem_enable_o = 1'b1;
                    mem_addr_o   = {cpu_addr_i[31:5], 5'b0};
                end
                UPDATE: begin
                    cpu_stall_o = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller.
// Cache contents are tracked as plain arrays; each access expands into its bus phases.
module tb_dcache_controller;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    dcache_controller dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_write_i (cpu_write_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected outputs for the current cycle
    bit           chkOn = 1'b0;
    logic         expStall;
    logic         expEn;
    logic         expWr;
    logic [31:0]  expAddr;
    logic [255:0] expMemData;
    bit           expChkData;
    logic [31:0]  expData;

    // reference cache
    bit           mValid [16];
    bit           mDirty [16];
    logic [22:0]  mTag   [16];
    logic [255:0] mData  [16];

    // per-access observations of the DUT
    int           stallCnt;
    int           enCnt;
    int           wbCnt;
    logic [31:0]  lastAlloc;
    logic [31:0]  lastWb;
    logic [31:0]  lastWbWord1;
    logic [31:0]  lastData;

    int           forceWait = -1;
    bit           useFill = 1'b0;
    logic [255:0] fillBlk;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    function automatic logic [255:0] randBlk();
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    task automatic expQuiet(input bit st, input bit chkD,
                            input logic [31:0] d);
        expStall   = st;
        expEn      = 1'b0;
        expWr      = 1'b0;
        expAddr    = '0;
        expMemData = '0;
        expChkData = chkD;
        expData    = d;
    endtask

    // Compare every cycle at the falling edge
    always @(negedge clk) begin
        if (chkOn) begin
            chk("stall", 256'(cpu_stall_o), 256'(expStall));
            chk("memEnable", 256'(mem_enable_o), 256'(expEn));
            chk("memWrite", 256'(mem_write_o), 256'(expWr));
            chk("memAddr", 256'(mem_addr_o), 256'(expAddr));
            chk("memData", mem_data_o, expMemData);
            if (expChkData) chk("cpuData", 256'(cpu_data_o), 256'(expData));
        end
    end

    task automatic sample();
        #1;
        if (cpu_stall_o) stallCnt++;
        if (mem_enable_o) begin
            enCnt++;
            if (mem_write_o) begin
                wbCnt++;
                lastWb      = mem_addr_o;
                lastWbWord1 = mem_data_o[63:32];
            end else begin
                lastAlloc = mem_addr_o;
            end
        end
        lastData = cpu_data_o;
    endtask

    task automatic access(input logic [31:0] a, input bit wr,
                          input logic [31:0] d);
        logic [3:0]   idx;
        logic [22:0]  tg;
        int           w;
        int           wt;
        logic [255:0] blk;
        idx      = a[8:5];
        tg       = a[31:9];
        w        = int'(a[4:2]);
        stallCnt = 0;
        enCnt    = 0;
        wbCnt    = 0;
        if (!(mValid[idx] && mTag[idx] == tg)) begin
            @(posedge clk); #1;
            cpu_req_i   = 1'b1;
            cpu_write_i = wr;
            cpu_addr_i  = a;
            cpu_data_i  = wr ? d : $urandom();
            mem_ack_i   = 1'($urandom_range(0, 1));
            mem_data_i  = randBlk();
            expQuiet(1'b1, 1'b1, 32'h0);
            sample();
            if (mValid[idx] && mDirty[idx]) begin
                wt = (forceWait >= 0) ? forceWait : $urandom_range(0, 4);
                for (int k = 0; k <= wt; k++) begin
                    @(posedge clk); #1;
                    cpu_req_i  = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    mem_ack_i  = (k == wt);
                    mem_data_i = randBlk();
                    expStall   = 1'b1;
                    expEn      = 1'b1;
                    expWr      = 1'b1;
                    expAddr    = {mTag[idx], idx, 5'b0};
                    expMemData = mData[idx];
                    expChkData = 1'b0;
                    sample();
                end
            end
            wt = (forceWait >= 0) ? forceWait : $urandom_range(0, 4);
            for (int k = 0; k <= wt; k++) begin
                @(posedge clk); #1;
                blk        = (k == wt && useFill) ? fillBlk : randBlk();
                cpu_req_i  = 1'b1;
                mem_ack_i  = (k == wt);
                mem_data_i = blk;
                expStall   = 1'b1;
                expEn      = 1'b1;
                expWr      = 1'b0;
                expAddr    = {a[31:5], 5'b0};
                expMemData = '0;
                expChkData = 1'b0;
                sample();
                if (k == wt) begin
                    mValid[idx] = 1'b1;
                    mDirty[idx] = 1'b0;
                    mTag[idx]   = tg;
                    mData[idx]  = blk;
                end
            end
            @(posedge clk); #1;
            cpu_req_i = 1'($urandom_range(0, 1));
            mem_ack_i = 1'($urandom_range(0, 1));
            expQuiet(1'b1, 1'b0, 32'h0);
            sample();
        end
        @(posedge clk); #1;
        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = a;
        cpu_data_i  = wr ? d : $urandom();
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_data_i  = randBlk();
        expQuiet(1'b0, 1'b1, wr ? 32'h0 : mData[idx][w*32 +: 32]);
        sample();
        if (wr) begin
            mData[idx][w*32 +: 32] = d;
            mDirty[idx] = 1'b1;
        end
    endtask

    task automatic idleCycle();
        @(posedge clk); #1;
        cpu_req_i   = 1'b0;
        cpu_write_i = 1'($urandom_range(0, 1));
        cpu_addr_i  = $urandom();
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_data_i  = randBlk();
        expQuiet(1'b0, 1'b1, 32'h0);
        sample();
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
            mTag[i]   = '0;
            mData[i]  = '0;
        end
        rst_i       = 1'b1;
        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'h0000_0104;
        cpu_data_i  = '0;
        mem_data_i  = '0;
        mem_ack_i   = 1'b1;
        expQuiet(1'b0, 1'b1, 32'h0);
        chkOn = 1'b1;
        #1;
        chk("resetStall", 256'(cpu_stall_o), 256'(0));
        chk("resetEnable", 256'(mem_enable_o), 256'(0));
        chk("resetData", 256'(cpu_data_o), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        mem_ack_i = 1'b0;

        // clean load miss with a pinned fetch block
        fillBlk        = randBlk();
        fillBlk[63:32] = 32'hDEAD_BEEF;
        useFill   = 1'b1;
        forceWait = 5;
        access(32'h0000_0104, 1'b0, 32'h0);
        chk("cleanMissStalls", 256'(stallCnt), 256'(8));
        chk("cleanMissData", 256'(lastData), 256'(32'hDEAD_BEEF));
        chk("cleanMissAddr", 256'(lastAlloc), 256'(32'h0000_0100));
        chk("cleanMissNoWb", 256'(wbCnt), 256'(0));
        useFill = 1'b0;

        // store hit then read back
        access(32'h0000_0104, 1'b1, 32'h1234_5678);
        chk("storeHitStalls", 256'(stallCnt), 256'(0));
        chk("storeHitBus", 256'(enCnt), 256'(0));
        access(32'h0000_0104, 1'b0, 32'h0);
        chk("storeReadBack", 256'(lastData), 256'(32'h1234_5678));

        // dirty eviction of the same index
        forceWait = 2;
        access(32'h0000_0304, 1'b0, 32'h0);
        chk("dirtyStalls", 256'(stallCnt), 256'(8));
        chk("dirtyWbAddr", 256'(lastWb), 256'(32'h0000_0100));
        chk("dirtyWbWord1", 256'(lastWbWord1), 256'(32'h1234_5678));
        chk("dirtyAllocAddr", 256'(lastAlloc), 256'(32'h0000_0300));
        chk("dirtyWbCycles", 256'(wbCnt), 256'(3));

        // idle bus with stray acks
        stallCnt = 0;
        enCnt    = 0;
        for (int i = 0; i < 20; i++) idleCycle();
        chk("idleStalls", 256'(stallCnt), 256'(0));
        chk("idleBus", 256'(enCnt), 256'(0));

        // reset while a fetch is outstanding, then a late ack
        @(posedge clk); #1;
        cpu_req_i   = 1'b1;
        cpu_write_i = 1'b0;
        cpu_addr_i  = 32'h0000_0104;
        mem_ack_i   = 1'b0;
        expQuiet(1'b1, 1'b1, 32'h0);
        sample();
        @(posedge clk); #1;
        expStall   = 1'b1;
        expEn      = 1'b1;
        expWr      = 1'b0;
        expAddr    = 32'h0000_0100;
        expMemData = '0;
        expChkData = 1'b0;
        sample();
        #1;
        rst_i = 1'b1;
        expQuiet(1'b0, 1'b1, 32'h0);
        #1;
        chk("midResetEnable", 256'(mem_enable_o), 256'(0));
        chk("midResetStall", 256'(cpu_stall_o), 256'(0));
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
        end
        @(posedge clk); #1;
        rst_i      = 1'b0;
        cpu_req_i  = 1'b0;
        mem_ack_i  = 1'b1;
        mem_data_i = randBlk();
        @(posedge clk); #1;
        mem_ack_i = 1'b0;

        // refill after reset, then back-to-back hits over the block
        for (int i = 0; i < 8; i++) fillBlk[i*32 +: 32] = 32'h0000_00A0 + i;
        useFill   = 1'b1;
        forceWait = 0;
        access(32'h0000_0104, 1'b0, 32'h0);
        chk("postResetMiss", 256'(stallCnt), 256'(3));
        useFill   = 1'b0;
        forceWait = -1;
        for (int i = 0; i < 8; i++) begin
            access(32'h0000_0100 + 32'(i * 4), 1'b0, 32'h0);
            chk("burstStall", 256'(stallCnt), 256'(0));
            chk("burstWord", 256'(lastData), 256'(32'h0000_00A0 + i));
        end

        // random traffic over a few aliasing tags
        for (int n = 0; n < 150; n++) begin
            a = (32'($urandom_range(0, 3)) << 9) |
                (32'($urandom_range(0, 15)) << 5) |
                (32'($urandom_range(0, 7)) << 2);
            access(a, 1'($urandom_range(0, 1)), $urandom());
            if ($urandom_range(0, 4) == 0) idleCycle();
        end

        @(posedge clk); #1;
        chkOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have no parameters; geometry is fixed at 16 lines, 32-byte blocks, direct-mapped, write-back, write-allocate.
REQ-002 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-high.
REQ-004 cpu_req_i  input  1  memory access request from the MEM stage, driven by MemRead or MemWrite.
REQ-005 cpu_write_i  input  1  1 = store, 0 = load; valid while cpu_req_i=1.
REQ-006 cpu_addr_i  input  32  byte address; fields are tag[31:9], index[8:5], word[4:2]; bits [1:0] ignored.
REQ-007 cpu_data_i  input  32  store data.
REQ-008 cpu_data_o  output  32  load data.
REQ-009 cpu_stall_o  output  1  freeze pipeline; the CPU holds the request stable while this is 1.
REQ-010 mem_enable_o  output  1  memory request, level-held until acknowledged.
REQ-011 mem_write_o  output  1  1 = block writeback, 0 = block fetch.
REQ-012 mem_addr_o  output  32  block-aligned address, with bits [4:0] equal to 0.
REQ-013 mem_data_o  output  256  writeback block.
REQ-014 mem_data_i  input  256  fetched block; valid in the cycle mem_ack_i=1.
REQ-015 mem_ack_i  input  1  single-cycle completion pulse from memory.

Function
REQ-016 Each line SHALL hold valid (1 bit), dirty (1 bit), tag (23 bits) and data (256 bits); word w occupies bits [32w+31:32w].
REQ-017 hit SHALL be combinational: cpu_req_i & valid[index] & (tag[index] == cpu_addr_i[31:9]).
REQ-018 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE and UPDATE.
REQ-019 In IDLE on a load hit, cpu_data_o SHALL equal the addressed word in the same cycle, and cpu_stall_o SHALL be 0.
REQ-020 In IDLE on a store hit, the addressed word SHALL be replaced and dirty set to 1 at the next edge, and cpu_stall_o SHALL be 0.
REQ-021 In IDLE with cpu_req_i=1 and no hit:
  - cpu_stall_o SHALL be 1 in that cycle.
  - The next state SHALL be WRITEBACK if the victim line is valid and dirty, otherwise ALLOCATE.
REQ-022 In WRITEBACK:
  - Outputs SHALL be mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim block.
  - The state SHALL hold until mem_ack_i=1, then move to ALLOCATE.
REQ-023 In ALLOCATE:
  - Outputs SHALL be mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu_addr_i[31:5], 5'b0}.
  - When mem_ack_i=1, the line SHALL be loaded with mem_data_i, tag set, valid set to 1, dirty cleared to 0, and the state SHALL move to UPDATE.
REQ-024 UPDATE SHALL last exactly one cycle and then return to IDLE, where the held request now hits and completes per REQ-019/020.
REQ-025 cpu_stall_o SHALL be 1 in every non-IDLE state.
REQ-026 Outside WRITEBACK and ALLOCATE, mem_enable_o, mem_write_o, mem_addr_o and mem_data_o SHALL all be 0.
REQ-027 cpu_data_o SHALL be 0 when cpu_req_i=0 or cpu_write_i=1.
REQ-028 mem_ack_i SHALL be ignored in IDLE and UPDATE.
REQ-029 A cpu_req_i drop while not in IDLE SHALL NOT abort the transaction; the sequence SHALL complete to IDLE.
REQ-030 Minimum miss latency SHALL be measured from the miss cycle to the cycle the request completes with stall 0:
  - Clean miss: 3 cycles plus the memory wait.
  - Dirty miss: 4 cycles plus both memory waits.

Reset
REQ-031 While rst_i=1, all valid and dirty bits SHALL clear, the state SHALL be IDLE, and all outputs SHALL be 0, taking effect immediately without waiting for a clock.
REQ-032 Reset asserted mid-WRITEBACK or mid-ALLOCATE SHALL drop mem_enable_o in the same cycle and abandon the transfer; no line SHALL be modified by a late mem_ack_i.
REQ-033 Tag and data arrays need not be reset.

Verification
REQ-034 Load miss, clean: after reset, load from 0x0000_0104 with memory acking after 5 cycles with word1 = 0xDEAD_BEEF -> one ALLOCATE to 0x100, stall for 5+3 cycles, then cpu_data_o = 0xDEAD_BEEF with stall 0.
REQ-035 Store hit: store 0x1234_5678 to 0x104 after REQ-034 -> no mem_enable_o and no stall; a following load of 0x104 returns 0x1234_5678.
REQ-036 Dirty eviction: load 0x0000_0304 (same index 8, different tag) -> WRITEBACK to 0x100 with mem_data_o word1 = 0x1234_5678, then ALLOCATE to 0x300, stall deasserts after UPDATE.
REQ-037 Reset during ALLOCATE: rst_i pulse mid-fetch, then mem_ack_i=1 -> mem_enable_o=0 immediately, state IDLE, and the next load of 0x104 misses.
REQ-038 Idle bus: cpu_req_i=0 with random mem_ack_i pulses -> no state change, stall 0, all mem_* outputs 0.
REQ-039 Back-to-back hits: 8 consecutive loads to 0x100-0x11C after fill -> zero stall cycles and correct words in order.
